acc_stage: RTL
==============

ACC_STAGE -- requirements
Module: acc_stage

Interface
REQ-001 Parameter LEN, default 4, data width of the signed sum from the adder and of the accumulator.
REQ-002 Parameter CNT, default 4, number of adder results accumulated per burst, legal range 1..15.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rsn  input  1  reset, synchronous, active-low.
REQ-005 i_valid  input  1  upstream adder result valid.
REQ-006 o_ready  output  1  stage accepts a result this cycle.
REQ-007 i_sum  input  LEN signed  adder sum (o_sum of the adder).
REQ-008 i_carry  input  1  adder signed-overflow flag (o_carry of the adder).
REQ-009 o_acc  output  LEN signed  saturated accumulated result.
REQ-010 o_ovf  output  1  sticky overflow/saturation flag for the current burst.
REQ-011 o_valid  output  1  burst result available.
REQ-012 i_ready  input  1  downstream accepts the burst result.
REQ-013 o_cnt  output  4  results accepted in the current burst.

Function
REQ-014 Handshake: a transfer occurs when i_valid and o_ready are both 1 at a rising edge; no other input sample is used.
REQ-015 FSM states: IDLE, ACC, DONE; o_ready = 1 in IDLE and ACC, 0 in DONE; o_valid = 1 only in DONE.
REQ-016 Input correction: if i_carry = 1, the effective operand is MAXP (2^(LEN-1)-1) when i_sum[LEN-1] = 1, else MINN (-2^(LEN-1)), and o_ovf is set; if i_carry = 0, the effective operand is i_sum.
REQ-017 Accumulation: acc + effective operand is computed in LEN+1 bits; a result above MAXP clamps to MAXP, below MINN clamps to MINN, and any clamp sets o_ovf.
REQ-018 IDLE with transfer: acc = effective operand (no addition), o_ovf = correction flag only (previous burst cleared), o_cnt = 1, next state ACC, or DONE if CNT = 1.
REQ-019 ACC with transfer: acc = saturated sum, o_ovf = o_ovf OR new flags, o_cnt increments; when o_cnt reaches CNT, next state DONE.
REQ-020 IDLE/ACC without transfer: all registers hold.
REQ-021 DONE: o_acc, o_ovf and o_cnt hold while i_ready = 0; when i_ready = 1, the next state is IDLE and output values remain visible until the next burst's first transfer.
REQ-022 Latency: o_valid rises one cycle after the CNT-th transfer; a new burst can start in the cycle after the DONE handshake, so there is no combinational i_ready-to-o_ready path.
REQ-023 o_cnt never exceeds CNT; i_valid in DONE is ignored and the input is not consumed.

Reset
REQ-024 When i_rsn = 0 at a rising edge: state IDLE, o_acc = 0, o_ovf = 0, o_cnt = 0, o_valid = 0, o_ready = 1 after reset.
REQ-025 Reset mid-burst or during DONE discards partial results and takes priority over any simultaneous transfer.

Structure
REQ-026 The FSM state enum (IDLE, ACC, DONE) shall live in shared package alu_pkg, alongside the saturation-bound helper functions MAXP/MINN of LEN.
REQ-027 The saturation adder (LEN+1-bit add, clamp, flag) shall be a combinational sub-module sat_add; acc_stage holds the FSM and registers.

Verification (LEN = 4, CNT = 4)
REQ-028 Sums 1, 2, 3, -1 with carry 0, i_ready = 1 -> o_acc = 5, o_ovf = 0, o_cnt = 4, o_valid for 1 cycle.
REQ-029 Sums 7, 1, 0, 0 -> o_acc = 7 (clamped), o_ovf = 1; sums -5, -5, 0, 0 -> o_acc = -8, o_ovf = 1.
REQ-030 First input i_sum = -8 with i_carry = 1 (4+4), then 0, 0, 0 -> o_acc = 7, o_ovf = 1; the next burst of 0s -> o_ovf = 0.
REQ-031 Burst complete, i_ready = 0 for 5 cycles with i_valid = 1 -> o_valid and o_acc stable, o_ready = 0, no input consumed; i_ready = 1 -> IDLE the next cycle.
REQ-032 i_rsn = 0 after 2 transfers with a simultaneous i_valid -> o_cnt = 0, o_acc = 0, IDLE; the next 4 transfers of 1 -> o_acc = 4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared FSM state encoding and saturation bounds for the accumulator stage.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Largest positive value representable in a len-bit two's complement word.
    function automatic int maxp(input int unsigned len);
        return (1 << (len - 1)) - 1;
    endfunction

    // Most negative value representable in a len-bit two's complement word.
    function automatic int minn(input int unsigned len);
        return -(1 << (len - 1));
    endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational LEN-bit signed saturating adder with a clamp flag.
module sat_add
    import alu_pkg::*;
#(
    parameter int unsigned LEN = 4
) (
    input  logic signed [LEN-1:0] i_a,
    input  logic signed [LEN-1:0] i_b,
    output logic signed [LEN-1:0] o_sum,
    output logic                  o_clamp
);

    localparam logic signed [LEN:0] MAXP_W = (LEN+1)'(maxp(LEN));
    localparam logic signed [LEN:0] MINN_W = (LEN+1)'(minn(LEN));

    logic signed [LEN:0] wide;

    // One guard bit is enough to see any overflow of a two-operand add.
    always_comb begin
        wide    = $signed({i_a[LEN-1], i_a}) + $signed({i_b[LEN-1], i_b});
        o_sum   = wide[LEN-1:0];
        o_clamp = 1'b0;
        if (wide > MAXP_W) begin
            o_sum   = MAXP_W[LEN-1:0];
            o_clamp = 1'b1;
        end else if (wide < MINN_W) begin
            o_sum   = MINN_W[LEN-1:0];
            o_clamp = 1'b1;
        end
    end

endmodule

// File: rtl/acc_stage.sv
// Burst accumulator: sums CNT saturated adder results and presents them with valid/ready.
module acc_stage
    import alu_pkg::*;
#(
    parameter int unsigned LEN = 4,
    parameter int unsigned CNT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rsn,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic signed [LEN-1:0] i_sum,
    input  logic                  i_carry,
    output logic signed [LEN-1:0] o_acc,
    output logic                  o_ovf,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [3:0]            o_cnt
);

    localparam logic signed [LEN-1:0] MAXP_L = LEN'(maxp(LEN));
    localparam logic signed [LEN-1:0] MINN_L = LEN'(minn(LEN));
    localparam logic [3:0]            CNT_W  = 4'(CNT);

    state_e                state_q;
    logic signed [LEN-1:0] acc_q;
    logic                  ovf_q;
    logic [3:0]            cnt_q;
    logic                  valid_q;
    logic                  ready_q;

    logic signed [LEN-1:0] opnd;
    logic signed [LEN-1:0] add_a;
    logic signed [LEN-1:0] acc_d;
    logic                  clamp;
    logic                  ovf_d;
    logic [3:0]            cnt_d;
    logic                  xfer;
    logic                  last;

    // A flagged adder overflow means the true sum lies beyond the range on the
    // side opposite to the wrapped sign bit.
    always_comb begin
        opnd = i_sum;
        if (i_carry) begin
            opnd = i_sum[LEN-1] ? MAXP_L : MINN_L;
        end
    end

    // The first operand of a burst is added to zero, so it loads unchanged.
    assign add_a = (state_q == IDLE) ? '0 : acc_q;

    sat_add #(.LEN(LEN)) u_sat_add (
        .i_a     (add_a),
        .i_b     (opnd),
        .o_sum   (acc_d),
        .o_clamp (clamp)
    );

    assign xfer  = i_valid & ready_q;
    assign ovf_d = i_carry | clamp | ((state_q == ACC) & ovf_q);
    assign cnt_d = (state_q == IDLE) ? 4'd1 : cnt_q + 4'd1;
    assign last  = (cnt_d == CNT_W);

    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    if (xfer) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_d;
                        cnt_q <= cnt_d;
                        if (last) begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_acc   = acc_q;
    assign o_ovf   = ovf_q;
    assign o_cnt   = cnt_q;
    assign o_valid = valid_q;
    assign o_ready = ready_q;

endmodule
